// File: rtl/mem_pkg.sv
// Shared types and defaults for the MFC-handshake memory responder.
package mem_pkg;

    localparam int LAT_W          = 4;
    localparam int DEF_ADDR_W     = 16;
    localparam int DEF_DATA_W     = 16;
    localparam int DEF_DEPTH_LOG2 = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } state_e;

endpackage

// File: rtl/mem_word_array.sv
// Word storage: synchronous write, combinational read, no reset so contents survive it.
module mem_word_array
    import mem_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int DEPTH_LOG2 = DEF_DEPTH_LOG2
) (
    input  logic                  clock,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] waddr,
    input  logic [DATA_W-1:0]     wdata,
    input  logic [DEPTH_LOG2-1:0] raddr,
    output logic [DATA_W-1:0]     rdata
);

    logic [DATA_W-1:0] mem_q [2**DEPTH_LOG2];

    always_ff @(posedge clock) begin
        if (we) mem_q[waddr] <= wdata;
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/memory_mfc_responder.sv
// Memory-side responder: latches a read/write strobe, waits LATENCY cycles,
// then completes the access and raises MFC until the initiator drops its strobe.
module memory_mfc_responder
    import mem_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int DEPTH_LOG2 = DEF_DEPTH_LOG2,
    parameter int LATENCY    = 3            // legal 1..15
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              read,
    input  logic              write,
    output logic [DATA_W-1:0] rdata,
    output logic              MFC,
    output logic              busy,
    output logic              err
);

    localparam logic [LAT_W-1:0] CNT_INIT = LAT_W'(LATENCY - 1);

    state_e                state_q;
    logic [LAT_W-1:0]      cnt_q;
    logic [DEPTH_LOG2-1:0] addr_q;
    logic [DATA_W-1:0]     wdata_q;
    logic                  op_wr_q;
    logic [DATA_W-1:0]     rdata_q;
    logic                  mfc_q, busy_q, err_q;

    logic [DATA_W-1:0]     mem_rd;
    logic                  op_level;
    logic                  complete;

    // Only the strobe of the latched operation keeps the transaction alive.
    assign op_level = op_wr_q ? write : read;
    assign complete = (state_q == ST_BUSY) && op_level && (cnt_q == '0);

    generate
        if (ADDR_W > DEPTH_LOG2) begin : g_addr_hi
            logic unused_addr_hi;
            assign unused_addr_hi = ^addr[ADDR_W-1:DEPTH_LOG2];
        end
    endgenerate

    mem_word_array #(
        .DATA_W     (DATA_W),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_array (
        .clock (clock),
        .we    (complete && op_wr_q),
        .waddr (addr_q),
        .wdata (wdata_q),
        .raddr (addr_q),
        .rdata (mem_rd)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            op_wr_q <= 1'b0;
            rdata_q <= '0;
            mfc_q   <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            err_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (read ^ write) begin
                        addr_q  <= addr[DEPTH_LOG2-1:0];
                        wdata_q <= wdata;
                        op_wr_q <= write;
                        cnt_q   <= CNT_INIT;
                        busy_q  <= 1'b1;
                        state_q <= ST_BUSY;
                    end else if (read && write) begin
                        err_q <= 1'b1;
                    end
                end
                ST_BUSY: begin
                    if (!op_level) begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else if (cnt_q == '0) begin
                        if (!op_wr_q) rdata_q <= mem_rd;
                        mfc_q   <= 1'b1;
                        state_q <= ST_DONE;
                    end else begin
                        cnt_q <= cnt_q - LAT_W'(1);
                    end
                end
                ST_DONE: begin
                    if (!op_level) begin
                        mfc_q   <= 1'b0;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign rdata = rdata_q;
    assign MFC   = mfc_q;
    assign busy  = busy_q;
    assign err   = err_q;

endmodule

// File: tb/tb_memory_mfc_responder.sv
// Bench for memory_mfc_responder: LATENCY=3 and LATENCY=1 instances against a word-array model.
module tb_memory_mfc_responder;

    logic        clk;
    logic        rst_n;
    logic [15:0] addr_s  [2];
    logic [15:0] wdata_s [2];
    logic        rd_s    [2];
    logic        wr_s    [2];
    logic [15:0] rdata_s [2];
    logic        mfc_s   [2];
    logic        busy_s  [2];
    logic        err_s   [2];

    int lat_of [2] = '{3, 1};

    logic [15:0] mdl   [2][256];
    bit          known [2][256];

    int n_checks = 0;
    int n_fail   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    memory_mfc_responder #(.LATENCY(3)) dut3 (
        .clock(clk), .reset(rst_n), .addr(addr_s[0]), .wdata(wdata_s[0]),
        .read(rd_s[0]), .write(wr_s[0]), .rdata(rdata_s[0]), .MFC(mfc_s[0]),
        .busy(busy_s[0]), .err(err_s[0])
    );

    memory_mfc_responder #(.LATENCY(1)) dut1 (
        .clock(clk), .reset(rst_n), .addr(addr_s[1]), .wdata(wdata_s[1]),
        .read(rd_s[1]), .write(wr_s[1]), .rdata(rdata_s[1]), .MFC(mfc_s[1]),
        .busy(busy_s[1]), .err(err_s[1])
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One full handshake; expected MFC edge comes from the instance's latency.
    task automatic txn(input int d, input bit is_wr, input logic [15:0] a, input logic [15:0] wd);
        int lat;
        int idx;
        int extra;
        lat = lat_of[d];
        idx = int'(a[7:0]);
        addr_s[d]  = a;
        wdata_s[d] = wd;
        if (is_wr) wr_s[d] = 1'b1; else rd_s[d] = 1'b1;
        for (int e = 0; e <= lat; e++) begin
            tick();
            chk("busy_during", busy_s[d], 1);
            chk("mfc_timing", mfc_s[d], (e == lat) ? 1 : 0);
            if (e < lat) begin
                addr_s[d]  = 16'($urandom);
                wdata_s[d] = 16'($urandom);
            end
        end
        if (is_wr) begin
            mdl[d][idx]   = wd;
            known[d][idx] = 1'b1;
        end else if (known[d][idx]) begin
            chk("rdata", rdata_s[d], mdl[d][idx]);
        end
        extra = $urandom_range(0, 2);
        for (int k = 0; k < extra; k++) begin
            if (k == 0) begin
                if (is_wr) rd_s[d] = 1'b1; else wr_s[d] = 1'b1;
            end
            tick();
            chk("mfc_hold", mfc_s[d], 1);
            chk("busy_hold", busy_s[d], 1);
            if (!is_wr && known[d][idx]) chk("rdata_hold", rdata_s[d], mdl[d][idx]);
        end
        rd_s[d] = 1'b0;
        wr_s[d] = 1'b0;
        tick();
        chk("mfc_drop", mfc_s[d], 0);
        chk("busy_drop", busy_s[d], 0);
        chk("err_drop", err_s[d], 0);
        if (!is_wr && known[d][idx]) chk("rdata_keep", rdata_s[d], mdl[d][idx]);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            addr_s[d] = '0; wdata_s[d] = '0; rd_s[d] = 1'b0; wr_s[d] = 1'b0;
            for (int i = 0; i < 256; i++) known[d][i] = 1'b0;
        end
        tick();
        tick();
        for (int d = 0; d < 2; d++) begin
            chk("rst_mfc", mfc_s[d], 0);
            chk("rst_busy", busy_s[d], 0);
            chk("rst_err", err_s[d], 0);
            chk("rst_rdata", rdata_s[d], 0);
        end
        rst_n = 1'b1;
        tick();

        txn(0, 1'b1, 16'h0005, 16'hBEEF);
        txn(0, 1'b0, 16'h0005, 16'h0000);

        // Abort: write strobe dropped after one busy cycle must not commit.
        txn(0, 1'b1, 16'h0007, 16'h5555);
        addr_s[0] = 16'h0007; wdata_s[0] = 16'h1234; wr_s[0] = 1'b1;
        tick();
        chk("abort_busy", busy_s[0], 1);
        wr_s[0] = 1'b0;
        tick();
        chk("abort_idle", busy_s[0], 0);
        chk("abort_mfc", mfc_s[0], 0);
        tick();
        chk("abort_mfc2", mfc_s[0], 0);
        txn(0, 1'b0, 16'h0007, 16'h0000);

        // Illegal: both strobes high in IDLE.
        rd_s[0] = 1'b1; wr_s[0] = 1'b1;
        for (int k = 0; k < 2; k++) begin
            tick();
            chk("illegal_err", err_s[0], 1);
            chk("illegal_mfc", mfc_s[0], 0);
            chk("illegal_busy", busy_s[0], 0);
        end
        rd_s[0] = 1'b0; wr_s[0] = 1'b0;
        tick();
        chk("illegal_err_clr", err_s[0], 0);
        txn(0, 1'b0, 16'h0005, 16'h0000);

        // Wrap: 0x0103 aliases word 3.
        txn(0, 1'b1, 16'h0103, 16'hA5A5);
        txn(0, 1'b0, 16'h0003, 16'h0000);

        // Reset mid-BUSY aborts at once and leaves storage intact.
        addr_s[0] = 16'h0003; wdata_s[0] = 16'h1111; wr_s[0] = 1'b1;
        tick();
        tick();
        chk("pre_rst_busy", busy_s[0], 1);
        rst_n = 1'b0;
        #1;
        chk("midrst_mfc", mfc_s[0], 0);
        chk("midrst_busy", busy_s[0], 0);
        chk("midrst_rdata", rdata_s[0], 0);
        wr_s[0] = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        txn(0, 1'b0, 16'h0003, 16'h0000);

        // LATENCY=1 back-to-back at minimum spacing.
        txn(1, 1'b1, 16'h00FF, 16'h3C3C);
        txn(1, 1'b0, 16'h00FF, 16'h0000);

        for (int it = 0; it < 60; it++) begin
            int          d;
            bit          w;
            logic [15:0] a;
            d = $urandom_range(0, 1);
            w = 1'($urandom_range(0, 1));
            a = 16'($urandom_range(0, 15)) | (16'($urandom_range(0, 3)) << 8);
            txn(d, w, a, 16'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/memory_mfc_responder.md
Name: memory_mfc_responder

Overview:
- Word-addressed memory that answers the CPU controller's read/write strobes on the memory side.
- Completion is signalled with the MFC (memory function complete) handshake.
- Sits between the MAR/MDR registers and the data bus.
- Latency is programmable so the controller's MFC wait states are exercised.

Parameters:
- ADDR_W, 16: width of addr (driven from MAR).
- DATA_W, 16: width of wdata/rdata.
- DEPTH_LOG2, 8: storage holds 2^DEPTH_LOG2 words; only addr[DEPTH_LOG2-1:0] is used.
- LATENCY, 3: cycles from request acceptance to MFC rise; legal range 1..15.

Ports:
- clock, input, 1: single clock; all state updates on posedge.
- reset, input, 1: asynchronous, active-low reset.
- addr, input, ADDR_W: word address from MAR.
- wdata, input, DATA_W: write data from MDR.
- read, input, 1: read request level, held by initiator until MFC seen.
- write, input, 1: write request level, held by initiator until MFC seen.
- rdata, output, DATA_W: read data, valid while MFC=1 after a read.
- MFC, output, 1: memory function complete.
- busy, output, 1: high in BUSY and DONE states.
- err, output, 1: one-cycle pulse on illegal request (read and write both high).

Behaviour:
- Reset (reset=0, async): state=IDLE, MFC=0, busy=0, err=0, rdata=0, counter=0.
  - Storage contents are not cleared; they persist across reset and are undefined at power-up.
- Reset asserted mid-operation: aborts immediately and no write is committed.
- State IDLE:
  - read^write high at a posedge (edge N): latch addr[DEPTH_LOG2-1:0], wdata and op into request registers, load counter=LATENCY-1, go to BUSY, busy=1.
  - read&write both high: stay IDLE, err=1 for exactly one cycle, re-evaluated every cycle while both remain high.
  - Otherwise remain IDLE.
- State BUSY:
  - Counter decrements each posedge.
  - Counter==0 at a posedge: go to DONE, MFC=1.
    - Write: storage[latched addr] <= latched wdata on this same edge.
    - Read: rdata <= storage[latched addr] on this same edge.
  - MFC therefore rises at edge N+LATENCY. With LATENCY=1, BUSY lasts one cycle.
  - Requested op level drops while in BUSY: return to IDLE, no write, no MFC (abort).
  - Input addr/wdata changes during BUSY are ignored because latched values are used.
- State DONE:
  - MFC=1 and rdata held stable until the requesting strobe is low at a posedge.
  - Then MFC=0, busy=0, back to IDLE. rdata keeps its last value.
  - A new request is accepted no earlier than the posedge after returning to IDLE. Back-to-back transactions are therefore LATENCY+2 cycles minimum.
  - The other strobe rising while in DONE is ignored until IDLE.
- Address wrap: upper address bits are discarded, so addr=0x0100 with DEPTH_LOG2=8 maps to word 0.
- Initiator domain: the initiator samples MFC on both clock edges, which is safe because MFC only changes on posedge.

Decomposition:
- Shared package mem_pkg:
  - State encoding constants ST_IDLE=2'b00, ST_BUSY=2'b01, ST_DONE=2'b10.
  - Counter width LAT_W=4.
  - Default ADDR_W/DATA_W/DEPTH_LOG2.
- One sub-module, mem_word_array:
  - 2^DEPTH_LOG2 x DATA_W storage.
  - Synchronous write with we/waddr/wdata; combinational read port.
- The responder FSM, counter and request latches live in memory_mfc_responder.

Test Plan:
- Reset then write: addr=0x0005, wdata=0xBEEF, write=1 at edge 0, LATENCY=3 -> MFC rises at edge 3, busy=1 edges 0..3. Drop write -> MFC=0 next edge.
- Readback: read=1 addr=0x0005 -> MFC at edge N+3 with rdata=0xBEEF, held until read drops. Changing addr to 0x0006 during BUSY does not change rdata.
- Abort: write=1 addr=0x0007 wdata=0x1234, drop write after 1 cycle -> no MFC. A later read of 0x0007 returns its prior value, not 0x1234.
- Illegal: read=1 and write=1 for 2 cycles in IDLE -> err=1 on each of those cycles, MFC=0, busy=0, no storage change.
- Wrap and reset persistence:
  - Write 0xA5A5 to addr=0x0103 (DEPTH_LOG2=8); read addr=0x0003 -> rdata=0xA5A5.
  - Pulse reset low mid-BUSY -> MFC=0, busy=0 immediately; the word written beforehand is still 0xA5A5 afterwards.
- LATENCY=1 build: back-to-back write/read of 0x00FF -> MFC one edge after acceptance, minimum transaction spacing is 3 cycles.
